ref_sub_scheduler: RTL and testbench
====================================

# ref_sub_scheduler

Frame sequencer for the reference-subtraction datapath. On each frame-start pulse it sweeps channels 0..N_CH-1 and issues one read per channel to the per-channel MUA/threshold/hash buffers. It looks up each channel's reference channel in a programmable table and presents one beat per channel to the ref_substract input (mua_valid, frame, ch, ch_ref, data, hash, thr). It throttles on the downstream FIFO's almost-full flag and counts frame overruns.

## Interface
- N_CH, 160, channels per frame sweep (2..4095)
- CH_W, 12, channel index width; equals ch_ref width
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, asynchronous assert, active-low
- frame_start  in  1  one-cycle pulse: start a sweep
- frame_no  in  32  frame number, sampled with frame_start
- fifo_afull  in  1  downstream FIFO programmable-full, stall request
- buf_rd_en  out  1  buffer read strobe
- buf_rd_addr  out  CH_W  buffer read address = channel index
- buf_mua, buf_thr, buf_hash  in  32 each  buffer data, valid the cycle after buf_rd_en
- cfg_we  in  1  reference-table write strobe
- cfg_addr  in  CH_W  table entry (channel)
- cfg_ref  in  CH_W  reference channel for cfg_addr
- cfg_en  in  1  channel-enable bit written with cfg_ref (used only under macro)
- mua_valid  out  1  output beat valid
- frameNo_out  out  32, chNo_out  out  CH_W, ch_ref_out  out  CH_W  beat fields
- mua_data, thr_data, ch_hash  out  32 each  beat fields
- busy  out  1  high while state != IDLE
- overrun_cnt  out  16  saturating count of dropped frame_start pulses

## Operation
- States: IDLE, SWEEP, DRAIN.
- IDLE: frame_start=1 latches frame_no, clears ch_cnt, and moves to SWEEP.
- SWEEP: each cycle with fifo_afull=0 issues buf_rd_en=1, buf_rd_addr=ch_cnt, and a table read of ch_cnt, then increments ch_cnt.
  - After issuing ch_cnt=N_CH-1, moves to DRAIN.
  - fifo_afull=1 holds ch_cnt with no read. Reads already in flight (at most 2 beats) still complete.
- DRAIN: one cycle to let the last read data land, then back to IDLE.
- buf_rd_en/buf_rd_addr are combinational from state, ch_cnt and fifo_afull.
- All beat outputs are registered.
- Table: N_CH×(CH_W+1) synchronous RAM, 1-cycle read.
  - Write on cfg_we takes effect from the next cycle.
  - Same-address read and write in one cycle returns the old value.
  - Contents are not reset; software programs the table before the first frame.
- frame_start while busy=1 (SWEEP or DRAIN) is ignored; overrun_cnt increments, saturating at 16'hFFFF.
- Each channel produces exactly one beat per sweep, in ascending channel order.

## Timing
- Reset: every output is 0 and state is IDLE. Reset mid-sweep drops in-flight reads; no beat appears after rst_n deasserts until a new frame_start. overrun_cnt clears.
- frame_start sampled at edge 0: buf_rd_en high in cycle 1 (channel 0), mua_valid high in cycle 3.
- Read-to-beat latency is fixed at 2 cycles: buf_rd_en in cycle k gives mua_valid in cycle k+2 carrying that channel's buf data and table entry.
- Unstalled sweep: N_CH consecutive beats, busy high for N_CH+1 cycles. A new frame_start is accepted on the first IDLE cycle.
- mua_valid is a 1-cycle pulse per beat. No downstream ready exists; throttling is by fifo_afull only. The FIFO threshold must leave ≥3 free entries.
- fifo_afull toggling every cycle: beats gap accordingly; no beat is lost or duplicated.
- Channel counter never wraps past N_CH-1.

## Configuration
- REF_SUB_SCHED_CHSKIP_EN defined:
  - A channel whose table enable bit is 0 still consumes its SWEEP slot (ch_cnt advances, subject to stall). It issues no buf_rd_en and produces no beat.
  - Latency of enabled channels is unchanged.
- Undefined: the enable bit and cfg_en are ignored, and every channel produces a beat.

## Test plan
- Reset, program ch_ref[i]=(i+1)%N_CH with N_CH=8, frame_start with frame_no=0x55 -> 8 beats in cycles 3..10 with chNo 0..7, ch_ref 1..7,0, frameNo 0x55, data matching buffer model; busy low at cycle 10.
- fifo_afull held high in cycles 3..6 of the sweep -> no reads while high; beats still ordered 0..7, none lost or duplicated, last beat delayed by 4 cycles.
- frame_start pulsed in cycle 4 of a sweep and again in the DRAIN cycle -> both ignored, overrun_cnt=2, single sweep output; next pulse in IDLE accepted.
- cfg_we to channel 5 (0→9) in the cycle channel 5's table read issues -> beat 5 carries ch_ref 0; the next frame carries 9.
- rst_n asserted mid-sweep after 3 beats -> outputs 0 immediately; no further beats; the next frame starts from channel 0.
- With REF_SUB_SCHED_CHSKIP_EN and channels 2,3 disabled -> 6 beats (chNo 0,1,4..7); sweep duration is unchanged at N_CH+1 cycles.

Source files
------------

// File: rtl/ref_sub_scheduler_if.sv
// Buffer read port and reference-subtraction beat bus driven by ref_sub_scheduler.
// The master side is the scheduler. The slave side is the buffers plus ref_substract.
interface ref_sub_scheduler_if #(
   parameter int CH_W = 12
);
   logic            buf_rd_en;
   logic [CH_W-1:0] buf_rd_addr;
   logic [31:0]     buf_mua;
   logic [31:0]     buf_thr;
   logic [31:0]     buf_hash;

   logic            mua_valid;
   logic [31:0]     frameNo_out;
   logic [CH_W-1:0] chNo_out;
   logic [CH_W-1:0] ch_ref_out;
   logic [31:0]     mua_data;
   logic [31:0]     thr_data;
   logic [31:0]     ch_hash;

   modport master (
      output buf_rd_en, buf_rd_addr,
      input  buf_mua, buf_thr, buf_hash,
      output mua_valid, frameNo_out, chNo_out, ch_ref_out, mua_data, thr_data, ch_hash
   );

   modport slave (
      input  buf_rd_en, buf_rd_addr,
      output buf_mua, buf_thr, buf_hash,
      input  mua_valid, frameNo_out, chNo_out, ch_ref_out, mua_data, thr_data, ch_hash
   );
endinterface

// File: rtl/ref_sub_scheduler.sv
// Frame sequencer: sweeps channels 0..N_CH-1 per frame_start, throttled by fifo_afull.
// Optional REF_SUB_SCHED_CHSKIP_EN: per-channel enable bit suppresses reads and beats.
module ref_sub_scheduler #(
   parameter int N_CH = 160,
   parameter int CH_W = 12
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 frame_start,
   input  logic [31:0]          frame_no,
   input  logic                 fifo_afull,
   input  logic                 cfg_we,
   input  logic [CH_W-1:0]      cfg_addr,
   input  logic [CH_W-1:0]      cfg_ref,
   input  logic                 cfg_en,
   output logic                 busy,
   output logic [15:0]          overrun_cnt,
   ref_sub_scheduler_if.master  bus
);

   localparam int              IDX_W   = $clog2(N_CH);
   localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [CH_W-1:0] ch_cnt;
   logic [31:0]     frame_q;
   logic            issue;
   logic            rd_en;
   logic            last_ch;
   logic            cfg_hit;

   logic            vld_p0;
   logic [CH_W-1:0] ch_p0;
   logic [CH_W-1:0] ref_p0;

   logic            vld_p1;
   logic [31:0]     frame_p1;
   logic [CH_W-1:0] ch_p1;
   logic [CH_W-1:0] ref_p1;
   logic [31:0]     mua_p1;
   logic [31:0]     thr_p1;
   logic [31:0]     hash_p1;

   logic [CH_W-1:0] ref_mem [N_CH];

   assign last_ch = (ch_cnt == LAST_CH);
   assign cfg_hit = cfg_we && (cfg_addr < CH_W'(N_CH));
   assign busy    = (state_q != IDLE);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE:    if (frame_start) state_d = SWEEP;
         SWEEP: begin
            if (!fifo_afull) begin
               issue = 1'b1;
               if (last_ch) state_d = DRAIN;
            end
         end
         DRAIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ch_cnt      <= '0;
         overrun_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && frame_start)
            ch_cnt <= '0;
         else if (issue && !last_ch)
            ch_cnt <= ch_cnt + CH_W'(1);
         if (frame_start && busy && overrun_cnt != 16'hFFFF)
            overrun_cnt <= overrun_cnt + 16'd1;
      end
   end

   // Frame number only changes in IDLE, so no beat of the previous sweep can still be in flight.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && frame_start)
         frame_q <= frame_no;
   end

`ifdef REF_SUB_SCHED_CHSKIP_EN
   // Enable bits live in flops so the read strobe can be gated in the issue cycle itself.
   logic [N_CH-1:0] ch_en_q;

   always_ff @(posedge clk) begin
      if (cfg_hit)
         ch_en_q[cfg_addr[IDX_W-1:0]] <= cfg_en;
   end

   assign rd_en = issue && ch_en_q[ch_cnt[IDX_W-1:0]];
`else
   logic unused_cfg_en;
   assign unused_cfg_en = cfg_en;
   assign rd_en         = issue;
`endif

   assign bus.buf_rd_en   = rd_en;
   assign bus.buf_rd_addr = ch_cnt;

   // Stage p0: table read issued alongside the buffer read
   always_ff @(posedge clk) begin
      if (cfg_hit)
         ref_mem[cfg_addr[IDX_W-1:0]] <= cfg_ref;
      if (rd_en) begin
         ref_p0 <= ref_mem[ch_cnt[IDX_W-1:0]];
         ch_p0  <= ch_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_p0 <= 1'b0;
      else        vld_p0 <= rd_en;
   end

   // Stage p1: buffer data has landed; register the complete beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1   <= 1'b0;
         frame_p1 <= '0;
         ch_p1    <= '0;
         ref_p1   <= '0;
         mua_p1   <= '0;
         thr_p1   <= '0;
         hash_p1  <= '0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            frame_p1 <= frame_q;
            ch_p1    <= ch_p0;
            ref_p1   <= ref_p0;
            mua_p1   <= bus.buf_mua;
            thr_p1   <= bus.buf_thr;
            hash_p1  <= bus.buf_hash;
         end
      end
   end

   assign bus.mua_valid   = vld_p1;
   assign bus.frameNo_out = frame_p1;
   assign bus.chNo_out    = ch_p1;
   assign bus.ch_ref_out  = ref_p1;
   assign bus.mua_data    = mua_p1;
   assign bus.thr_data    = thr_p1;
   assign bus.ch_hash     = hash_p1;

endmodule

// File: tb/tb_ref_sub_scheduler.sv
// Scoreboard bench for ref_sub_scheduler: stimulus pushes expected beats, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_ref_sub_scheduler;

   localparam int N  = 8;
   localparam int CW = 12;

   typedef struct packed {
      logic [31:0] frame;
      logic [CW-1:0] ch;
      logic [CW-1:0] rf;
      logic [31:0] mua;
      logic [31:0] thr;
      logic [31:0] hash;
   } beat_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          frame_start = 1'b0;
   logic [31:0]   frame_no = '0;
   logic          fifo_afull = 1'b0;
   logic          cfg_we = 1'b0;
   logic [CW-1:0] cfg_addr = '0;
   logic [CW-1:0] cfg_ref = '0;
   logic          cfg_en = 1'b0;
   logic          busy;
   logic [15:0]   overrun_cnt;

   ref_sub_scheduler_if #(.CH_W(CW)) bus ();

   ref_sub_scheduler #(.N_CH(N), .CH_W(CW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .frame_no    (frame_no),
      .fifo_afull  (fifo_afull),
      .cfg_we      (cfg_we),
      .cfg_addr    (cfg_addr),
      .cfg_ref     (cfg_ref),
      .cfg_en      (cfg_en),
      .busy        (busy),
      .overrun_cnt (overrun_cnt),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   always @(posedge clk) cyc++;

   // Buffer contents, regenerated at every accepted frame
   logic [31:0] mua_mem [N];
   logic [31:0] thr_mem [N];
   logic [31:0] hash_mem [N];

   always @(posedge clk) begin
      if (bus.buf_rd_en) begin
         bus.buf_mua  <= mua_mem[int'(bus.buf_rd_addr) % N];
         bus.buf_thr  <= thr_mem[int'(bus.buf_rd_addr) % N];
         bus.buf_hash <= hash_mem[int'(bus.buf_rd_addr) % N];
      end
   end

   // Reference model: channels left in the sweep, a drain flag, the table, the overrun counter
   logic [CW-1:0] tbl [N];
`ifdef REF_SUB_SCHED_CHSKIP_EN
   bit            en_tbl [N];
`endif
   int            m_left = 0;
   bit            m_drain = 1'b0;
   int            m_ovr = 0;
   bit            m_rd = 1'b0;
   int            m_rd_addr = 0;
   logic [31:0]   m_frame = '0;
   beat_t         exp_q [$];
   int            due_q [$];

   task automatic step(input bit fs, input logic [31:0] fno, input bit af,
                       input bit we, input int wa, input int wr, input bit wen);
      bit busy_now, accept, slot, slot_en;
      int ch, nxt_left, nxt_ovr;
      bit nxt_drain;
      frame_start = fs;
      frame_no    = fno;
      fifo_afull  = af;
      cfg_we      = we;
      cfg_addr    = CW'(wa);
      cfg_ref     = CW'(wr);
      cfg_en      = wen;

      busy_now  = (m_left > 0) || m_drain;
      accept    = fs && !busy_now;
      nxt_left  = m_left;
      nxt_drain = 1'b0;
      nxt_ovr   = m_ovr;
      if (fs && busy_now && m_ovr < 16'hFFFF) nxt_ovr = m_ovr + 1;

      if (accept) begin
         m_frame  = fno;
         nxt_left = N;
         for (int i = 0; i < N; i++) begin
            mua_mem[i]  = $urandom;
            thr_mem[i]  = $urandom;
            hash_mem[i] = $urandom;
         end
      end

      slot = (m_left > 0) && !af;
      m_rd = 1'b0;
      if (slot) begin
         ch      = N - m_left;
         slot_en = 1'b1;
`ifdef REF_SUB_SCHED_CHSKIP_EN
         slot_en = en_tbl[ch];
`endif
         if (slot_en) begin
            m_rd      = 1'b1;
            m_rd_addr = ch;
            exp_q.push_back(beat_t'{frame: m_frame, ch: CW'(ch), rf: tbl[ch],
                                    mua: mua_mem[ch], thr: thr_mem[ch], hash: hash_mem[ch]});
            due_q.push_back(cyc + 2);
         end
         nxt_left  = m_left - 1;
         nxt_drain = (m_left == 1);
      end

      // Table writes land after this cycle's read, so the read above saw the old value
      if (we && wa < N) begin
         tbl[wa] = CW'(wr);
`ifdef REF_SUB_SCHED_CHSKIP_EN
         en_tbl[wa] = wen;
`endif
      end

      @(posedge clk);
      m_left  = nxt_left;
      m_drain = nxt_drain;
      m_ovr   = nxt_ovr;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset(input int hold);
      logic [255:0] outs;
      rst_n       = 1'b0;
      frame_start = 1'b0;
      fifo_afull  = 1'b0;
      cfg_we      = 1'b0;
      exp_q.delete();
      due_q.delete();
      m_left  = 0;
      m_drain = 1'b0;
      m_ovr   = 0;
      m_rd    = 1'b0;
      #1;
      outs = {bus.mua_valid, bus.frameNo_out, bus.chNo_out, bus.ch_ref_out, bus.mua_data,
              bus.thr_data, bus.ch_hash, busy, overrun_cnt, bus.buf_rd_en, bus.buf_rd_addr};
      n_cmp++;
      if (outs !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs got %h required all zero", outs);
      end
      repeat (hold) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // Monitor
   beat_t e_b, a_b;
   int    e_due;
   always @(negedge clk) begin
      while (due_q.size() > 0 && due_q[0] < cyc) begin
         e_b   = exp_q.pop_front();
         e_due = due_q.pop_front();
         n_cmp++;
         n_bad++;
         $display("FAIL beat_missing ch=%0d due cycle %0d, none by cycle %0d", e_b.ch, e_due, cyc);
      end
      if (rst_n && bus.mua_valid) begin
         a_b = beat_t'{frame: bus.frameNo_out, ch: bus.chNo_out, rf: bus.ch_ref_out,
                       mua: bus.mua_data, thr: bus.thr_data, hash: bus.ch_hash};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL beat_extra got %h at cycle %0d, required no beat", a_b, cyc);
         end else begin
            e_b   = exp_q.pop_front();
            e_due = due_q.pop_front();
            if (a_b !== e_b || cyc != e_due) begin
               n_bad++;
               $display("FAIL beat got %h at cycle %0d required %h at cycle %0d", a_b, cyc, e_b, e_due);
            end
         end
      end
      n_cmp++;
      if (busy !== ((m_left > 0) || m_drain) || overrun_cnt !== 16'(m_ovr)) begin
         n_bad++;
         $display("FAIL ctrl busy=%b ovr=%0d required busy=%b ovr=%0d", busy, overrun_cnt,
                  (m_left > 0) || m_drain, m_ovr);
      end
      n_cmp++;
      if (bus.buf_rd_en !== m_rd || (m_rd && bus.buf_rd_addr !== CW'(m_rd_addr))) begin
         n_bad++;
         $display("FAIL buf_read en=%b addr=%0d required en=%b addr=%0d", bus.buf_rd_en,
                  bus.buf_rd_addr, m_rd, m_rd_addr);
      end
   end

   initial begin
      do_reset(2);

      // Ring table, channels 2 and 3 marked disabled (only meaningful with channel skip)
      for (int i = 0; i < N; i++) step(0, 0, 0, 1, i, (i + 1) % N, !(i == 2 || i == 3));
      idle(2);

      // Plain sweep
      step(1, 32'h55, 0, 0, 0, 0, 0);
      idle(12);

      // Stall in cycles 3..6 of the sweep
      for (int r = 0; r < 20; r++) step(r == 0, 32'h66, (r >= 3 && r <= 6), 0, 0, 0, 0);
      idle(4);

      // Overrun pulses mid-sweep and in DRAIN, then accepted in IDLE
      for (int r = 0; r < 11; r++)
         step(r == 0 || r == 4 || r == 9 || r == 10,
              (r == 0) ? 32'h77 : (r == 10) ? 32'h78 : 32'hBAD, 0, 0, 0, 0, 0);
      idle(12);

      // Table write to channel 5 in the very cycle its read issues
      step(0, 0, 0, 1, 5, 0, 1);
      for (int r = 0; r < 12; r++) step(r == 0, 32'h99, 0, r == 6, 5, 9, 1);
      step(1, 32'h9A, 0, 0, 0, 0, 0);
      idle(12);

      // Reset after three beats, then a fresh frame
      for (int r = 0; r < 6; r++) step(r == 0, 32'hA0, 0, 0, 0, 0, 0);
      do_reset(2);
      idle(3);
      step(1, 32'hA1, 0, 0, 0, 0, 0);
      idle(12);

      // Randomized traffic: sparse frames, random or toggling stalls, live table rewrites
      for (int r = 0; r < 1500; r++) begin
         bit af;
         af = ((r / 200) % 2 == 1) ? cyc[0] : ($urandom_range(0, 2) == 0);
         step($urandom_range(0, 9) == 0, $urandom, af,
              $urandom_range(0, 14) == 0, $urandom_range(0, N - 1), $urandom_range(0, N - 1),
              $urandom_range(0, 3) != 0);
      end
      idle(20);

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_beats got %0d pending required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
